uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//   Consumer end of the store-path UART port (uart[7:0] / uartWe). Each uartWe pulse
//   carries one byte from a store to UART_ADDR. The byte is pushed into a small FIFO,
//   then serialised on txd as 8N1, LSB first, at a fixed baud rate.
//   Sits beside data memory in the memory-access stage; the core never stalls on it.
// PARAMETERS
//   CLK_FREQ_HZ  50_000_000  core clock frequency
//   BAUD_RATE    115_200     line rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer divide, DIV>=2)
//   FIFO_DEPTH   16          byte entries; power of two, >=2
// PORTS
//   clk       in   1   core clock, rising edge
//   rstN      in   1   synchronous reset, active-low
//   uart      in   8   byte to transmit; valid only when uartWe=1
//   uartWe    in   1   push strobe; one byte per high cycle
//   txd       out  1   serial line; idle high
//   busy      out  1   high while a frame is on the line or the FIFO is non-empty
//   full      out  1   FIFO holds FIFO_DEPTH entries
//   overflow  out  1   sticky; set when a push is dropped, cleared only by reset
// BEHAVIOUR
//   Reset (rstN=0 at an edge): txd=1, busy=0, full=0, overflow=0, FIFO emptied,
//     FSM=IDLE, baud counter=0, bit index=0. Reset mid-frame aborts the frame at once;
//     txd is 1 from the next cycle.
//   Push: uartWe=1 && !full -> the byte is written at that edge.
//     uartWe=1 && full -> byte dropped, overflow<=1. Push never depends on a same-cycle
//     pop. full and busy are registered outputs.
//   FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..DIV-1; a bit ends
//     when the counter is at DIV-1.
//     IDLE: txd=1. If FIFO is non-empty: pop the head into shift reg and go to START.
//     START: txd=0 for DIV cycles, then DATA with bit index=0.
//     DATA: txd=shift[0] for DIV cycles per bit; shift right; after bit 7, go to STOP.
//     STOP: txd=1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go to
//       START (no idle gap); else go to IDLE.
//   Latency: push at edge N into an empty FIFO with FSM in IDLE -> txd falls after
//     edge N+1. Frame length is exactly 10*DIV cycles.
//   Simultaneous push and pop: both occur; count is unchanged. Pointers wrap modulo
//     FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide.
//   busy = (state!=IDLE) || (count!=0). It is low only when the line is idle and
//     nothing is queued.
//   txd is driven from a flop (glitch-free).
// STRUCTURE
//   Shared package MemoryTypes:
//     UartTxState enum {UART_IDLE, UART_START, UART_DATA, UART_STOP}
//     UART_DATA_BITS=8
//   UART_ADDR stays where it already lives.
//   One sub-module, uart_tx_fifo:
//     synchronous FIFO, parameter DEPTH
//     ports clk, rstN, push, pushData, pop, popData, empty, full
//     popData is combinational from the head.
//   The top level holds the FSM, baud counter, shift register and overflow flag.
// TESTING  (bench: CLK_FREQ_HZ=8_000, BAUD_RATE=1_000 -> DIV=8; FIFO_DEPTH=4)
//   1. Reset with rstN=0 for 3 cycles -> txd=1, busy=0, full=0, overflow=0; txd stays 1
//      for 100 idle cycles.
//   2. Single push of 8'hA5 -> txd low from edge+1 for 8 cycles, then bits 1,0,1,0,0,1,0,1
//      at 8 cycles each, then stop=1; busy falls exactly 80 cycles after txd fell.
//   3. Back-to-back pushes 8'h55 and 8'h0F on consecutive cycles -> two frames with no
//      gap; second start bit begins at cycle 80 after the first; receiver model decodes
//      0x55 then 0x0F.
//   4. Six consecutive pushes 0x01..0x06 while idle -> first byte is popped into the
//      shifter; full=1 after the 5th push; 6th dropped; overflow=1;
//      line carries 0x01..0x05 only.
//   5. rstN=0 during DATA bit 3 of 0xFF with 2 bytes queued -> next cycle txd=1, busy=0;
//      no further frames.
//   6. Push when count=4 in the same cycle as STOP->START pop (FIFO_DEPTH=4) -> push
//      dropped (full honoured), overflow=1; count goes 4->3.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared memory-stage types: UART transmitter states and byte width.
// UART_ADDR is defined with the rest of the memory map, not here.
package MemoryTypes;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } UartTxState;

  // Clock cycles per serial bit (integer divide; callers keep the result >= 2).
  function automatic int uart_div(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Store-path UART port: byte strobe from the memory stage plus line/status back.
interface uart_tx_buffered_if;
  import MemoryTypes::*;

  logic [UART_DATA_BITS-1:0] uart;
  logic                      uartWe;
  logic                      txd;
  logic                      busy;
  logic                      full;
  logic                      overflow;

  modport master (
    output uart, uartWe,
    input  txd, busy, full, overflow
  );

  modport slave (
    input  uart, uartWe,
    output txd, busy, full, overflow
  );

endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous byte FIFO for the UART transmitter; head is visible combinationally.
// Push is gated only by the registered full flag, never by a same-cycle pop.
module uart_tx_fifo
  import MemoryTypes::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] pushData,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] popData,
  output logic                      empty,
  output logic                      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic [CNT_W-1:0]          w_count_next;
  logic                      r_empty;
  logic                      r_full;
  logic                      w_do_push;
  logic                      w_do_pop;

  assign w_do_push = push && !r_full;
  assign w_do_pop  = pop && !r_empty;

  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == CNT_W'(DEPTH));
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= pushData;
  end

  assign popData = r_mem[r_rd_ptr];
  assign empty   = r_empty;
  assign full    = r_full;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter fed by single-cycle store strobes.
// Holds the frame FSM, baud counter, shift register and sticky overflow flag.
module uart_tx_buffered
  import MemoryTypes::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic               clk,
  input  logic               rstN,
  uart_tx_buffered_if.slave  bus
);

  localparam int DIV    = uart_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W  = $clog2(UART_DATA_BITS);

  UartTxState                r_state;
  UartTxState                w_state_next;
  logic [BAUD_W-1:0]         r_baud_cnt;
  logic [BAUD_W-1:0]         w_baud_cnt_next;
  logic [BIT_W-1:0]          r_bit_idx;
  logic [BIT_W-1:0]          w_bit_idx_next;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_next;
  logic                      r_txd;
  logic                      w_txd_next;
  logic                      r_overflow;
  logic                      w_bit_end;
  logic                      w_pop;
  logic                      w_fifo_empty;
  logic                      w_fifo_full;
  logic [UART_DATA_BITS-1:0] w_pop_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstN     (rstN),
    .push     (bus.uartWe),
    .pushData (bus.uart),
    .pop      (w_pop),
    .popData  (w_pop_data),
    .empty    (w_fifo_empty),
    .full     (w_fifo_full)
  );

  assign w_bit_end = (r_baud_cnt == BAUD_W'(DIV - 1));

  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_pop           = 1'b0;

    case (r_state)
      UART_IDLE: begin
        w_baud_cnt_next = '0;
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_pop_data;
          w_state_next = UART_START;
        end
      end

      UART_START: begin
        if (w_bit_end) begin
          w_baud_cnt_next = '0;
          w_bit_idx_next  = '0;
          w_state_next    = UART_DATA;
        end else begin
          w_baud_cnt_next = r_baud_cnt + BAUD_W'(1);
        end
      end

      UART_DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_next = '0;
          w_shift_next    = r_shift >> 1;
          if (r_bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
            w_state_next = UART_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + BIT_W'(1);
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + BAUD_W'(1);
        end
      end

      UART_STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_next = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_pop_data;
            w_state_next = UART_START;
          end else begin
            w_state_next = UART_IDLE;
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt + BAUD_W'(1);
        end
      end

      default: w_state_next = UART_IDLE;
    endcase

    // The line level is decoded from the upcoming state so txd leaves a flop.
    case (w_state_next)
      UART_START: w_txd_next = 1'b0;
      UART_DATA:  w_txd_next = w_shift_next[0];
      default:    w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state    <= UART_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_txd      <= w_txd_next;
      if (bus.uartWe && w_fifo_full) r_overflow <= 1'b1;
    end
  end

  assign bus.txd      = r_txd;
  assign bus.full     = w_fifo_full;
  assign bus.overflow = r_overflow;
  assign bus.busy     = (r_state != UART_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed frame table, corner sequences,
// and random pushes compared each cycle against a queue/frame-schedule model.
module tb_uart_tx_buffered;
  import MemoryTypes::*;

  localparam int CLK_HZ = 8_000;
  localparam int BAUD   = 1_000;
  localparam int DIV    = 8;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * DIV;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  uart_tx_buffered_if bus();

  uart_tx_buffered #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  bit chk_on = 1'b0;

  // Reference model: pending-byte queue plus the start edge of the frame on the line.
  logic [7:0] m_q[$];
  bit         m_act   = 1'b0;
  logic [7:0] m_cur   = 8'h00;
  int         m_edge  = 0;
  int         m_start = 0;
  bit         m_ovf   = 1'b0;

  // Line receiver: samples mid-bit, keeps every byte with a valid stop bit.
  logic [7:0] rx_q[$];
  bit         rx_act  = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_byte = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;     // line level per bit slot, slot 0 = start bit
    int         lat;       // cycles from push edge sample to first low sample
    int         busy_len;  // cycles from first low sample until busy low
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] model_out();
    int   k;
    logic t;
    k = m_edge - m_start;
    if (!m_act)             t = 1'b1;
    else if (k < DIV)       t = 1'b0;
    else if (k < 9 * DIV)   t = m_cur[(k - DIV) / DIV];
    else                    t = 1'b1;
    return {t, (m_act || (m_q.size() != 0)), (m_q.size() == DEPTH), m_ovf};
  endfunction

  task automatic model_step();
    int pre;
    m_edge++;
    if (!rstN) begin
      m_q.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
    end else begin
      pre = m_q.size();
      if (m_act && (m_edge == m_start + FRAME)) m_act = 1'b0;
      if (!m_act && pre > 0) begin
        m_cur   = m_q.pop_front();
        m_act   = 1'b1;
        m_start = m_edge;
      end
      if (bus.uartWe) begin
        if (pre < DEPTH) m_q.push_back(bus.uart);
        else             m_ovf = 1'b1;
      end
    end
  endtask

  task automatic rx_step();
    int slot;
    if (!rstN) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (bus.txd === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
    end
    if (rx_act && (rx_cnt % DIV == DIV / 2)) begin
      slot = rx_cnt / DIV;
      if (slot >= 1 && slot <= 8) rx_byte[slot-1] = bus.txd;
      if (slot == 9) begin
        if (bus.txd === 1'b1) rx_q.push_back(rx_byte);
        rx_act = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    rx_step();
    if (chk_on)
      check($sformatf("cycle_model@%0d", m_edge),
            {28'd0, bus.txd, bus.busy, bus.full, bus.overflow}, {28'd0, model_out()});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input logic [7:0] d);
    bus.uart   = d;
    bus.uartWe = 1'b1;
    cycle();
    bus.uartWe = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < max) begin
      cycle();
      n++;
    end
    check({name, "_drain"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int         ones, zeros, rx0, lat, k, bfall, pct;
    logic [9:0] got;
    logic       a, b;

    vecs[0] = '{8'hA5, 10'b1101001010, 1, FRAME};
    vecs[1] = '{8'h00, 10'b1000000000, 1, FRAME};
    vecs[2] = '{8'hFF, 10'b1111111110, 1, FRAME};
    vecs[3] = '{8'h01, 10'b1000000010, 1, FRAME};
    vecs[4] = '{8'h80, 10'b1100000000, 1, FRAME};

    bus.uart   = 8'h00;
    bus.uartWe = 1'b0;

    // Reset held for three edges, then idle line.
    rstN = 1'b0;
    cycles(3);
    check("rst_txd",      {31'd0, bus.txd},      32'd1);
    check("rst_busy",     {31'd0, bus.busy},     32'd0);
    check("rst_full",     {31'd0, bus.full},     32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    rstN   = 1'b1;
    chk_on = 1'b1;
    ones = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (bus.txd === 1'b1) ones++;
    end
    check("idle_txd_ones", ones, 100);

    // Single-frame table.
    for (int v = 0; v < 5; v++) begin
      push(vecs[v].data);
      lat = 0;
      while (bus.txd !== 1'b0 && lat < 10) begin
        cycle();
        lat++;
      end
      check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
      k = 0;
      bfall = -1;
      got = '0;
      while (bfall < 0 && k < 100) begin
        if ((k % DIV == DIV / 2) && k < FRAME) got[k/DIV] = bus.txd;
        if (bus.busy === 1'b0) bfall = k;
        else begin
          cycle();
          k++;
        end
      end
      check($sformatf("vec%0d_frame", v), {22'd0, got}, {22'd0, vecs[v].frame});
      check($sformatf("vec%0d_busy_len", v), bfall, vecs[v].busy_len);
    end

    // Back-to-back pushes: frames abut with no idle gap.
    rx0 = rx_q.size();
    push(8'h55);
    push(8'h0F);
    check("b2b_first_start", {31'd0, bus.txd}, 32'd0);
    cycles(FRAME - 1);
    a = bus.txd;
    cycle();
    b = bus.txd;
    check("b2b_stop_then_start", {30'd0, a, b}, 32'd2);
    wait_idle(300, "b2b");
    check("b2b_rx_count", rx_q.size() - rx0, 2);
    check("b2b_rx0", {24'd0, rx_q[rx0]},   32'h55);
    check("b2b_rx1", {24'd0, rx_q[rx0+1]}, 32'h0F);

    // Six pushes into a depth-4 FIFO: one goes to the shifter, one is dropped.
    rx0 = rx_q.size();
    for (int i = 1; i <= 6; i++) begin
      push(8'(i));
      if (i == 4) check("fill_not_full_after_4", {31'd0, bus.full}, 32'd0);
      if (i == 5) check("fill_full_after_5",     {31'd0, bus.full}, 32'd1);
    end
    check("fill_overflow", {31'd0, bus.overflow}, 32'd1);
    wait_idle(600, "fill");
    check("fill_rx_count", rx_q.size() - rx0, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("fill_rx%0d", i), {24'd0, rx_q[rx0+i]}, i + 1);

    // Reset in the middle of data bit 3 with two bytes queued.
    rx0 = rx_q.size();
    push(8'hFF);
    push(8'h11);
    push(8'h22);
    cycles(34);
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    rstN = 1'b0;
    cycle();
    rstN = 1'b1;
    check("abort_txd",      {31'd0, bus.txd},      32'd1);
    check("abort_busy",     {31'd0, bus.busy},     32'd0);
    check("abort_full",     {31'd0, bus.full},     32'd0);
    check("abort_overflow", {31'd0, bus.overflow}, 32'd0);
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (bus.txd !== 1'b1) zeros++;
    end
    check("abort_no_frames", zeros, 0);
    check("abort_rx_none", rx_q.size() - rx0, 0);

    // Push at count=4 on the very edge the STOP bit pops the next byte.
    rx0 = rx_q.size();
    for (int i = 0; i < 5; i++) push(8'h31 + 8'(i));
    cycles(FRAME - 4);
    check("race_full_before", {31'd0, bus.full},     32'd1);
    check("race_ovf_before",  {31'd0, bus.overflow}, 32'd0);
    push(8'h77);
    check("race_overflow",   {31'd0, bus.overflow}, 32'd1);
    check("race_full_after", {31'd0, bus.full},     32'd0);
    check("race_restart",    {31'd0, bus.txd},      32'd0);
    wait_idle(500, "race");
    check("race_rx_count", rx_q.size() - rx0, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("race_rx%0d", i), {24'd0, rx_q[rx0+i]}, 32'h31 + i);

    // Random traffic in bursts of varying density, with occasional resets.
    pct = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) pct = ($urandom_range(0, 3) == 0) ? 40 : int'($urandom_range(0, 2));
      rstN       = (i % 1000 == 600) ? 1'b0 : 1'b1;
      bus.uartWe = (int'($urandom_range(0, 99)) < pct);
      bus.uart   = 8'($urandom());
      cycle();
    end
    bus.uartWe = 1'b0;
    rstN       = 1'b1;
    wait_idle((DEPTH + 2) * FRAME, "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
